// File: rtl/selfadd_acc_lanes.sv
// selfadd_acc_lanes
//   Multi-lane self-accumulating register bank. Each lane sums LOOP
//   consecutive accepted input beats; the completed group sums of all lanes
//   are presented together in a single-entry output register that is
//   drained with a valid/ready handshake.
//
// Parameters
//   W     : lane / accumulator width
//   LANES : number of independent lanes (lane i at bits [i*W +: W])
//   LOOP  : beats per group (>= 1)
//   SAT   : 0 = wrap-around add, 1 = unsigned saturation at 2^W-1
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   in_v     : input beat valid
//   in_rdy   : input ready (beat accepted when in_v && in_rdy)
//   in_data  : packed input beat, LANES*W bits
//   clr      : synchronous clear of the partial group
//   halt     : freezes input acceptance
//   out_v    : group result valid
//   out_rdy  : downstream ready (result consumed when out_v && out_rdy)
//   out_data : packed group sums, LANES*W bits
//   out_ovf  : per-lane overflow flag of the presented group
module selfadd_acc_lanes #(
  parameter int W     = 16,
  parameter int LANES = 2,
  parameter int LOOP  = 3,
  parameter int SAT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_v,
  output logic                 in_rdy,
  input  logic [LANES*W-1:0]   in_data,
  input  logic                 clr,
  input  logic                 halt,
  output logic                 out_v,
  input  logic                 out_rdy,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_ovf
);

  localparam int CW = (LOOP > 1) ? $clog2(LOOP) : 1;

  logic [CW-1:0]        r_cnt;
  logic [LANES*W-1:0]   r_acc;
  logic [LANES-1:0]     r_ovf_acc;
  logic                 r_out_v;
  logic [LANES*W-1:0]   r_out_data;
  logic [LANES-1:0]     r_out_ovf;

  logic                 w_first;
  logic                 w_last;
  logic                 w_in_rdy;
  logic                 w_take;
  logic [LANES*W-1:0]   w_nacc;
  logic [LANES-1:0]     w_novf;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CW'(LOOP - 1));

  // The final beat only stalls while the output register is full and is
  // not being drained this cycle; a drain frees the slot for the new group.
  assign w_in_rdy = rst && !halt && !clr && !(w_last && r_out_v && !out_rdy);
  assign w_take   = in_v && w_in_rdy;

  // Per-lane W+1 bit adder; bit W is the carry. On the first beat the
  // accumulator is bypassed so the group starts from the input value.
  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    logic [W:0] w_sum;
    assign w_sum = {1'b0, (w_first ? {W{1'b0}} : r_acc[g*W +: W])}
                 + {1'b0, in_data[g*W +: W]};
    // Saturating mode clamps on carry; a clamped value plus anything
    // carries again (or adds zero), so it stays clamped.
    assign w_nacc[g*W +: W] = ((SAT != 0) && w_sum[W]) ? {W{1'b1}} : w_sum[W-1:0];
    assign w_novf[g]        = (w_first ? 1'b0 : r_ovf_acc[g]) | w_sum[W];
  end

  // Accumulator and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ovf_acc <= '0;
    end else if (clr) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ovf_acc <= '0;
    end else if (w_take) begin
      r_acc     <= w_nacc;
      r_ovf_acc <= w_novf;
      r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

  // Output register: a completing group overrides a same-cycle drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_v    <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= '0;
    end else if (w_take && w_last) begin
      r_out_v    <= 1'b1;
      r_out_data <= w_nacc;
      r_out_ovf  <= w_novf;
    end else if (r_out_v && out_rdy) begin
      r_out_v    <= 1'b0;
    end
  end

  assign in_rdy   = w_in_rdy;
  assign out_v    = r_out_v;
  assign out_data = r_out_data;
  assign out_ovf  = r_out_ovf;

endmodule

// File: tb/tb_selfadd_acc_lanes.sv
module tb_selfadd_acc_lanes;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_v;
  logic        clr;
  logic        halt;
  logic        out_rdy;
  logic [31:0] in_data;

  logic        in_rdy_w,  in_rdy_s;
  logic        out_v_w,   out_v_s;
  logic [31:0] out_data_w, out_data_s;
  logic [1:0]  out_ovf_w, out_ovf_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Wrap-around instance
  selfadd_acc_lanes #(.W(16), .LANES(2), .LOOP(3), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy_w), .in_data(in_data),
    .clr(clr), .halt(halt), .out_v(out_v_w), .out_rdy(out_rdy),
    .out_data(out_data_w), .out_ovf(out_ovf_w)
  );

  // Saturating instance, driven in lockstep
  selfadd_acc_lanes #(.W(16), .LANES(2), .LOOP(3), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy_s), .in_data(in_data),
    .clr(clr), .halt(halt), .out_v(out_v_s), .out_rdy(out_rdy),
    .out_data(out_data_s), .out_ovf(out_ovf_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] l0, input logic [15:0] l1);
    in_v    = 1'b1;
    in_data = {l1, l0};
    tick();
    in_v    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_v = 1'b1; in_data = 32'h0001_0001;
    clr = 1'b0; halt = 1'b0; out_rdy = 1'b1;
    #2;
    checks++;
    if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy_w); end
    checks++;
    if (out_v_w !== 1'b0 || out_data_w !== 32'h0 || out_ovf_w !== 2'b00) begin
      errors++; $display("FAIL reset_out got v=%b d=%h o=%b exp v=0 d=0 o=0", out_v_w, out_data_w, out_ovf_w);
    end
    in_v = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_rdy_w !== 1'b1) begin errors++; $display("FAIL reset_release_rdy got=%b exp=1", in_rdy_w); end
  endtask

  task automatic test_basic();
    beat(16'd1, 16'd2);
    checks++;
    if (out_v_w !== 1'b0) begin errors++; $display("FAIL basic_b1_v got=%b exp=0", out_v_w); end
    beat(16'd3, 16'd4);
    beat(16'd5, 16'd6);
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd12, 16'd9} || out_ovf_w !== 2'b00) begin
      errors++; $display("FAIL basic_sum got v=%b d=%h o=%b exp v=1 d=000c0009 o=00", out_v_w, out_data_w, out_ovf_w);
    end
    tick();
    checks++;
    if (out_v_w !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_v_w); end
  endtask

  task automatic test_back_to_back();
    logic exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      in_v = 1'b1;
      in_data = {16'(10 * k), 16'(k)};
      tick();
      checks++;
      if (out_v_w !== exp_v[k-1]) begin errors++; $display("FAIL b2b_v beat=%0d got=%b exp=%b", k, out_v_w, exp_v[k-1]); end
      if (k == 3) begin
        checks++;
        if (out_data_w !== {16'd60, 16'd6}) begin errors++; $display("FAIL b2b_g1 got=%h exp=003c0006", out_data_w); end
      end
      if (k == 6) begin
        checks++;
        if (out_data_w !== {16'd150, 16'd15}) begin errors++; $display("FAIL b2b_g2 got=%h exp=0096000f", out_data_w); end
      end
    end
    in_v = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    beat(16'hFFFF, 16'h0000);
    beat(16'h0002, 16'h0000);
    beat(16'h0001, 16'h0000);
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== 32'h0000_0002 || out_ovf_w !== 2'b01) begin
      errors++; $display("FAIL wrap_ovf got v=%b d=%h o=%b exp v=1 d=00000002 o=01", out_v_w, out_data_w, out_ovf_w);
    end
    checks++;
    if (out_v_s !== 1'b1 || out_data_s !== 32'h0000_FFFF || out_ovf_s !== 2'b01) begin
      errors++; $display("FAIL sat_ovf got v=%b d=%h o=%b exp v=1 d=0000ffff o=01", out_v_s, out_data_s, out_ovf_s);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    beat(16'd1, 16'd1);
    beat(16'd2, 16'd2);
    beat(16'd3, 16'd3);
    beat(16'd10, 16'd20);
    beat(16'd10, 16'd20);
    in_v = 1'b1; in_data = {16'd20, 16'd10};
    #1;
    checks++;
    if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL bp_stall_rdy got=%b exp=0", in_rdy_w); end
    tick();
    tick();
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd6, 16'd6}) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=00060006", out_v_w, out_data_w);
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if (in_rdy_w !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", in_rdy_w); end
    tick();
    in_v = 1'b0;
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd60, 16'd30}) begin
      errors++; $display("FAIL bp_new got v=%b d=%h exp v=1 d=003c001e", out_v_w, out_data_w);
    end
    tick();
    checks++;
    if (out_v_w !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_v_w); end
  endtask

  task automatic test_clr();
    beat(16'd5, 16'd5);
    beat(16'd7, 16'd7);
    clr = 1'b1; in_v = 1'b1; in_data = {16'd9, 16'd9};
    #1;
    checks++;
    if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL clr_rdy got=%b exp=0", in_rdy_w); end
    tick();
    clr = 1'b0; in_v = 1'b0;
    checks++;
    if (out_v_w !== 1'b0) begin errors++; $display("FAIL clr_no_out got=%b exp=0", out_v_w); end
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd3, 16'd3}) begin
      errors++; $display("FAIL clr_sum got v=%b d=%h exp v=1 d=00030003", out_v_w, out_data_w);
    end
    tick();
  endtask

  task automatic test_halt();
    out_rdy = 1'b0;
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd2, 16'd4);
    halt = 1'b1; out_rdy = 1'b1; in_v = 1'b1; in_data = {16'd100, 16'd100};
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_rdy_w !== 1'b0) begin errors++; $display("FAIL halt_rdy cyc=%0d got=%b exp=0", c, in_rdy_w); end
      tick();
      checks++;
      if (out_v_w !== 1'b0) begin errors++; $display("FAIL halt_drain cyc=%0d got=%b exp=0", c, out_v_w); end
    end
    halt = 1'b0; in_v = 1'b0;
    beat(16'd3, 16'd5);
    beat(16'd4, 16'd6);
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd15, 16'd9}) begin
      errors++; $display("FAIL halt_sum got v=%b d=%h exp v=1 d=000f0009", out_v_w, out_data_w);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd1, 16'd1);
    beat(16'd5, 16'd5);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (out_v_w !== 1'b0 || out_data_w !== 32'h0 || out_ovf_w !== 2'b00 || in_rdy_w !== 1'b0) begin
      errors++; $display("FAIL rst_mid got v=%b d=%h o=%b rdy=%b exp all 0", out_v_w, out_data_w, out_ovf_w, in_rdy_w);
    end
    tick();
    rst = 1'b1; out_rdy = 1'b1;
    beat(16'd2, 16'd3);
    beat(16'd2, 16'd3);
    checks++;
    if (out_v_w !== 1'b0) begin errors++; $display("FAIL rst_mid_partial got=%b exp=0", out_v_w); end
    beat(16'd2, 16'd3);
    checks++;
    if (out_v_w !== 1'b1 || out_data_w !== {16'd9, 16'd6}) begin
      errors++; $display("FAIL rst_mid_sum got v=%b d=%h exp v=1 d=00090006", out_v_w, out_data_w);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_clr();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
